// File: rtl/i2s.sv
// I2S receive master for a 24-bit stereo ADC: derives scki/bck/lrck from one
// free-running counter and deserialises din into left/right sample registers.
module i2s (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic        bck,
    output logic        lrck,
    output logic        scki,
    output logic [23:0] left,
    output logic [23:0] right
);

    logic [8:0]  cnt_q,   cnt_d;
    logic [23:0] sr_q,    sr_d;
    logic [23:0] left_q,  left_d;
    logic [23:0] right_q, right_d;

    logic [4:0]  slot;
    logic        sample_en;
    logic        in_word;
    logic        load_en;
    logic [23:0] word_next;

    // din is sampled one clk after the bck rising edge, mid-bit.
    assign slot      = cnt_q[7:3];
    assign sample_en = (cnt_q[2:0] == 3'b101);
    assign in_word   = (slot >= 5'd1) && (slot <= 5'd24);
    assign load_en   = sample_en && (slot == 5'd24);
    assign word_next = {sr_q[22:0], din};

    always_comb begin
        cnt_d   = cnt_q + 9'd1;
        sr_d    = sr_q;
        left_d  = left_q;
        right_d = right_q;
        if (sample_en && in_word) begin
            sr_d = word_next;
        end
        if (load_en) begin
            if (cnt_q[8] == 1'b0) begin
                left_d = word_next;
            end else begin
                right_d = word_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= 9'd0;
            sr_q    <= 24'd0;
            left_q  <= 24'd0;
            right_q <= 24'd0;
        end else begin
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    // Clocks come straight from counter bits, so they are glitch-free.
    assign scki  = cnt_q[0];
    assign bck   = cnt_q[2];
    assign lrck  = cnt_q[8];
    assign left  = left_q;
    assign right = right_q;

endmodule

// File: tb/tb_i2s.sv
// Self-checking bench for i2s: an ADC-side model drives din from per-frame word
// tables, and a frame-position reference predicts clocks and sample outputs.
module tb_i2s;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        din = 1'b1;
    logic        bck, lrck, scki;
    logic [23:0] left, right;

    i2s dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .bck   (bck),
        .lrck  (lrck),
        .scki  (scki),
        .left  (left),
        .right (right)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          pos    = 0;   // position within frame, 0..511
    int          frame_idx = 0;
    logic [23:0] lw [0:8];
    logic [23:0] rw [0:8];
    logic [23:0] exp_l = 24'd0;
    logic [23:0] exp_r = 24'd0;
    logic        prev_scki = 1'b0, prev_bck = 1'b0, prev_lrck = 1'b0;
    int          rise_scki = 0, rise_bck = 0, rise_lrck = 0;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %06h, expected %06h (frame %0d pos %0d)",
                     tag, obs, exp, frame_idx, pos);
        end
    endtask

    // ADC model: new bit presented at each bck falling edge (pos multiple of 8).
    task automatic drive_din();
        int          s;
        logic [23:0] w;
        if (pos % 8 == 0) begin
            s = (pos / 8) % 32;
            w = (pos >= 256) ? rw[frame_idx] : lw[frame_idx];
            if (s >= 1 && s <= 24) begin
                din = w[24 - s];
            end else if (frame_idx <= 2) begin
                din = 1'b1;
            end else begin
                din = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic check_outputs();
        chk("scki",  {23'd0, scki}, 24'(pos % 2));
        chk("bck",   {23'd0, bck},  24'((pos / 4) % 2));
        chk("lrck",  {23'd0, lrck}, 24'(pos / 256));
        chk("left",  left,  exp_l);
        chk("right", right, exp_r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (reset) begin
            pos = (pos + 1) % 512;
            if (pos == 0) frame_idx++;
            if (pos == 198) begin
                exp_l = lw[frame_idx];
                $display("frame %0d: left load  expected %06h observed %06h", frame_idx, exp_l, left);
            end
            if (pos == 454) begin
                exp_r = rw[frame_idx];
                $display("frame %0d: right load expected %06h observed %06h", frame_idx, exp_r, right);
            end
        end
        drive_din();
        check_outputs();
        if (scki && !prev_scki) rise_scki++;
        if (bck  && !prev_bck)  rise_bck++;
        if (lrck && !prev_lrck) rise_lrck++;
        prev_scki = scki;
        prev_bck  = bck;
        prev_lrck = lrck;
    endtask

    initial begin
        int budget;
        lw[0] = 24'hA5C3F0; rw[0] = 24'h123456;
        lw[1] = 24'hFFFFFF; rw[1] = 24'h000000;
        lw[2] = 24'h000000; rw[2] = 24'hFFFFFF;
        for (int i = 3; i < 8; i++) begin
            lw[i] = 24'($urandom);
            rw[i] = 24'($urandom);
        end
        lw[8] = 24'd0; rw[8] = 24'd0;

        // Reset held for 10 clk: everything at zero.
        reset = 1'b0;
        pos = 0;
        frame_idx = 0;
        drive_din();
        for (int i = 0; i < 10; i++) tick();

        // Release and count clock periods over exactly one frame.
        reset = 1'b1;
        rise_scki = 0; rise_bck = 0; rise_lrck = 0;
        for (int i = 0; i < 512; i++) tick();
        chk("scki_periods", 24'(rise_scki), 24'd256);
        chk("bck_periods",  24'(rise_bck),  24'd64);
        chk("lrck_periods", 24'(rise_lrck), 24'd1);

        // Run frames; abort frame 3 mid-left-word with an asynchronous reset.
        budget = 20000;
        while (frame_idx < 8 && budget > 0) begin
            tick();
            budget--;
            if (frame_idx == 3 && pos == 100 && reset) begin
                reset = 1'b0;
                #1;
                exp_l = 24'd0;
                exp_r = 24'd0;
                chk("rst_left",  left,  24'd0);
                chk("rst_right", right, 24'd0);
                chk("rst_lrck",  {23'd0, lrck}, 24'd0);
                pos = 0;
                frame_idx = 4;
                drive_din();
                for (int i = 0; i < 3; i++) tick();
                reset = 1'b1;
            end
        end
        chk("run_done", 24'(frame_idx), 24'd8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
